// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter and its pin driver.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    RECOVER = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic lb_n;
    logic ub_n;
  } strobe_t;

  localparam strobe_t STROBES_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, lb_n: 1'b1, ub_n: 1'b1};

endpackage

// File: rtl/sram_pin_driver.sv
// Registered SRAM pins, DQ tri-state and read capture; a read lands on rd_valid_o 2 cycles after accept.
// Pure datapath: the arbiter above decides what loads, and nothing here can stall.
module sram_pin_driver
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_rd_i,
  input  logic              load_wr_i,
  input  logic              recover_i,
  input  logic              capture_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [1:0]        wr_be_i,
  inout  wire  [DATA_W-1:0] sram_dq_io,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic              sram_lb_n_o,
  output logic              sram_ub_n_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o
);

  strobe_t           strb_d, strb_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] dq_out_d, dq_out_q;
  logic              dq_oe_d, dq_oe_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  always_comb begin
    strb_d   = STROBES_IDLE;
    addr_d   = addr_q;
    dq_out_d = dq_out_q;
    dq_oe_d  = 1'b0;
    if (load_wr_i) begin
      addr_d   = wr_addr_i;
      dq_out_d = wr_data_i;
      dq_oe_d  = 1'b1;
      strb_d   = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, lb_n: ~wr_be_i[0], ub_n: ~wr_be_i[1]};
    end else if (load_rd_i) begin
      addr_d = rd_addr_i;
      strb_d = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, lb_n: 1'b0, ub_n: 1'b0};
    end else if (recover_i) begin
      // WE has risen; keep address and data on the bus for hold time
      dq_oe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strb_q     <= STROBES_IDLE;
      addr_q     <= '0;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      strb_q     <= strb_d;
      addr_q     <= addr_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      rd_valid_q <= capture_i;
      if (capture_i) rd_data_q <= sram_dq_io;
    end
  end

  assign sram_dq_io  = dq_oe_q ? dq_out_q : 'z;
  assign sram_addr_o = addr_q;
  assign sram_ce_n_o = strb_q.ce_n;
  assign sram_oe_n_o = strb_q.oe_n;
  assign sram_we_n_o = strb_q.we_n;
  assign sram_lb_n_o = strb_q.lb_n;
  assign sram_ub_n_o = strb_q.ub_n;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Display-priority read/write arbiter for the async frame SRAM; reads return 2 cycles after accept.
// Acks are combinational; no accept in WRITE, and the writer is forced in after MAX_RD_RUN display grants.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_RD_RUN = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_be,
  output logic              wr_ack,
  inout  wire  [DATA_W-1:0] sram_DQ,
  output logic [ADDR_W-1:0] sram_ADDR,
  output logic              sram_LB_N,
  output logic              sram_UB_N,
  output logic              sram_CE_N,
  output logic              sram_OE_N,
  output logic              sram_WE_N
);

  localparam logic [7:0] RunLimit = 8'(MAX_RD_RUN);

  arb_state_e state_q, state_d;
  logic [7:0] starve_q, starve_d;
  logic       can_accept, wr_wins;

  assign can_accept = reset_n && (state_q != WRITE);
  assign wr_wins    = wr_req && (!rd_req || (starve_q >= RunLimit));
  assign wr_ack     = can_accept && wr_wins;
  assign rd_ack     = can_accept && rd_req && !wr_wins;

  always_comb begin
    state_d = IDLE;
    if (wr_ack)                state_d = WRITE;
    else if (rd_ack)           state_d = READ;
    else if (state_q == WRITE) state_d = RECOVER;

    // Counts display grants only while a write is actually pending
    starve_d = starve_q;
    if (!wr_req || wr_ack)                  starve_d = '0;
    else if (rd_ack && starve_q != 8'hFF)   starve_d = starve_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  sram_pin_driver #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pins (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_rd_i   (rd_ack),
    .load_wr_i   (wr_ack),
    .recover_i   (state_q == WRITE),
    .capture_i   (state_q == READ),
    .rd_addr_i   (rd_addr),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_be_i     (wr_be),
    .sram_dq_io  (sram_DQ),
    .sram_addr_o (sram_ADDR),
    .sram_ce_n_o (sram_CE_N),
    .sram_oe_n_o (sram_OE_N),
    .sram_we_n_o (sram_WE_N),
    .sram_lb_n_o (sram_LB_N),
    .sram_ub_n_o (sram_UB_N),
    .rd_valid_o  (rd_valid),
    .rd_data_o   (rd_data)
  );

endmodule
